// File: rtl/scan_select_seq_pkg.sv
// rtl/scan_select_seq_pkg.sv - shared types, pattern codes and width helpers for scan_select_seq
package scan_sel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int PAT_ALL_ZERO      = 0;
  localparam int PAT_ALL_WORD_SAME = 1;

  function automatic int pat_uncompressible(input int num_patterns);
    return num_patterns - 1;
  endfunction

  function automatic int len_encode_w(input int num_patterns);
    return (num_patterns > 1) ? $clog2(num_patterns) : 1;
  endfunction

  function automatic int zrl_w(input int num_rows);
    return $clog2(num_rows + 1);
  endfunction

endpackage

// File: rtl/scan_select_seq_if.sv
// rtl/scan_select_seq_if.sv - block-in / selection-out handshake bundle for scan_select_seq
interface scan_select_seq_if #(
  parameter int LEN_ENCODE      = 3,
  parameter int BLOCK_W         = 256,
  parameter int NUM_TRANSFORMER = 5,
  parameter int ZRL_W           = 5
);
  logic                               valid_i;
  logic                               ready_o;
  logic                               isAllZero_i;
  logic                               isAllWordSame_i;
  logic [BLOCK_W*NUM_TRANSFORMER-1:0] scanned_i;
  logic                               valid_o;
  logic                               ready_i;
  logic [LEN_ENCODE-1:0]              select_o;
  logic [BLOCK_W-1:0]                 sel_scanned_o;
  logic [ZRL_W-1:0]                   zeroRunLen_o;

  modport master (
    output valid_i, isAllZero_i, isAllWordSame_i, scanned_i, ready_i,
    input  ready_o, valid_o, select_o, sel_scanned_o, zeroRunLen_o
  );

  modport slave (
    input  valid_i, isAllZero_i, isAllWordSame_i, scanned_i, ready_i,
    output ready_o, valid_o, select_o, sel_scanned_o, zeroRunLen_o
  );
endinterface

// File: rtl/scan_select_seq_zrl_count.sv
// rtl/scan_select_seq_zrl_count.sv - combinational count of leading all-zero rows (row 0 in the MSBs)
module scan_zrl_count #(
  parameter int ROW_WIDTH = 16,
  parameter int NUM_ROWS  = 16,
  localparam int BLOCK_W  = ROW_WIDTH * NUM_ROWS,
  localparam int ZRL_W    = $clog2(NUM_ROWS + 1)
) (
  input  logic [BLOCK_W-1:0] data,
  output logic [ZRL_W-1:0]   zrl
);

  logic hit_one;

  always_comb begin
    zrl     = '0;
    hit_one = 1'b0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!hit_one) begin
        if (data[BLOCK_W-1-r*ROW_WIDTH -: ROW_WIDTH] == '0) zrl = zrl + ZRL_W'(1);
        else                                              hit_one = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_select_seq.sv
// rtl/scan_select_seq.sv - buffered one-candidate-per-cycle zero-run-length pattern selector
// Optional SCAN_SEL_EARLY_EXIT_EN: stop scanning at the first fully zero candidate.
module scan_select_seq
  import scan_sel_pkg::*;
#(
  parameter int NUM_PATTERNS          = 8,
  parameter int NUM_FIRST_TRANSFORMER = 2,
  parameter int NUM_LAST_TRANSFORMER  = 6,
  parameter int ROW_WIDTH             = 16,
  parameter int NUM_ROWS              = 16,
  parameter int MIN_ZRL               = 1
) (
  input logic          clk_i,
  input logic          rst_i,
  scan_select_seq_if.slave bus
);

  localparam int NUM_TRANSFORMER = NUM_LAST_TRANSFORMER - NUM_FIRST_TRANSFORMER + 1;
  localparam int LEN_ENCODE      = len_encode_w(NUM_PATTERNS);
  localparam int BLOCK_W         = ROW_WIDTH * NUM_ROWS;
  localparam int ZRL_W           = zrl_w(NUM_ROWS);
  localparam int IDX_W           = (NUM_TRANSFORMER > 1) ? $clog2(NUM_TRANSFORMER) : 1;

  localparam logic [LEN_ENCODE-1:0] SEL_ZERO   = LEN_ENCODE'(PAT_ALL_ZERO);
  localparam logic [LEN_ENCODE-1:0] SEL_SAME   = LEN_ENCODE'(PAT_ALL_WORD_SAME);
  localparam logic [LEN_ENCODE-1:0] SEL_UNCOMP = LEN_ENCODE'(pat_uncompressible(NUM_PATTERNS));
  localparam logic [LEN_ENCODE-1:0] SEL_FIRST  = LEN_ENCODE'(NUM_FIRST_TRANSFORMER);

  state_t state, state_nx;

  logic [BLOCK_W-1:0]    cand_q [NUM_TRANSFORMER];
  logic [IDX_W-1:0]      idx_q, idx_nx, best_idx_q, best_idx_nx, fin_idx;
  logic [ZRL_W-1:0]      best_zrl_q, best_zrl_nx, fin_zrl, cur_zrl;
  logic [LEN_ENCODE-1:0] select_q, select_nx;
  logic [BLOCK_W-1:0]    data_q, data_nx;
  logic [ZRL_W-1:0]      zrl_q, zrl_nx;
  logic                  accept, last_cand;

  assign bus.ready_o       = (state == ST_IDLE) && !rst_i;
  assign bus.valid_o       = (state == ST_DONE);
  assign bus.select_o      = select_q;
  assign bus.sel_scanned_o = data_q;
  assign bus.zeroRunLen_o  = zrl_q;
  assign accept            = bus.valid_i && bus.ready_o;

  // Candidate buffer is pure data; the FSM decides whether it is ever looked at.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int i = 0; i < NUM_TRANSFORMER; i++)
        cand_q[i] <= bus.scanned_i[(NUM_TRANSFORMER-1-i)*BLOCK_W +: BLOCK_W];
    end
  end

  scan_zrl_count #(
    .ROW_WIDTH (ROW_WIDTH),
    .NUM_ROWS  (NUM_ROWS)
  ) u_zrl (
    .data (cand_q[idx_q]),
    .zrl  (cur_zrl)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_zrl_q <= '0;
      select_q   <= '0;
      data_q     <= '0;
      zrl_q      <= '0;
    end else begin
      state      <= state_nx;
      idx_q      <= idx_nx;
      best_idx_q <= best_idx_nx;
      best_zrl_q <= best_zrl_nx;
      select_q   <= select_nx;
      data_q     <= data_nx;
      zrl_q      <= zrl_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx_q;
    best_idx_nx = best_idx_q;
    best_zrl_nx = best_zrl_q;
    select_nx   = select_q;
    data_nx     = data_q;
    zrl_nx      = zrl_q;

    // Strictly greater keeps the lower pattern index on ties.
    fin_zrl = (cur_zrl > best_zrl_q) ? cur_zrl : best_zrl_q;
    fin_idx = (cur_zrl > best_zrl_q) ? idx_q   : best_idx_q;
`ifdef SCAN_SEL_EARLY_EXIT_EN
    last_cand = (idx_q == IDX_W'(NUM_TRANSFORMER - 1)) || (cur_zrl == ZRL_W'(NUM_ROWS));
`else
    last_cand = (idx_q == IDX_W'(NUM_TRANSFORMER - 1));
`endif

    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (bus.isAllZero_i) begin
            state_nx  = ST_DONE;
            select_nx = SEL_ZERO;
            data_nx   = '0;
            zrl_nx    = '0;
          end else if (bus.isAllWordSame_i) begin
            state_nx  = ST_DONE;
            select_nx = SEL_SAME;
            data_nx   = '0;
            zrl_nx    = '0;
          end else begin
            state_nx    = ST_SCAN;
            idx_nx      = '0;
            best_idx_nx = '0;
            best_zrl_nx = '0;
          end
        end
      end
      ST_SCAN: begin
        idx_nx      = idx_q + IDX_W'(1);
        best_idx_nx = fin_idx;
        best_zrl_nx = fin_zrl;
        if (last_cand) begin
          state_nx = ST_DONE;
          zrl_nx   = fin_zrl;
          if (fin_zrl < ZRL_W'(MIN_ZRL)) begin
            select_nx = SEL_UNCOMP;
            data_nx   = '0;
          end else begin
            select_nx = SEL_FIRST + LEN_ENCODE'(fin_idx);
            data_nx   = cand_q[fin_idx];
          end
        end
      end
      ST_DONE: begin
        if (bus.ready_i) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
